tisc_control_unit: RTL

- Multi-cycle fetch/decode/execute/writeback controller for the TISC core.
- Sits directly upstream of the 8x8-bit register file.
- Fetches 16-bit instructions over a req/valid handshake, drives the register file read addresses and samples its combinational read data, computes the result in an internal ALU, and issues exactly one write-enable pulse per writing instruction.
- Owns the PC and the halt state.

---
 rtl/tisc_pkg.sv | 47 ++++
 rtl/tisc_control_unit_if.sv | 29 ++
 rtl/tisc_alu.sv | 30 +++
 rtl/tisc_control_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/tisc_pkg.sv
// Shared definitions for the TISC control path: opcodes, FSM states,
// instruction field positions and small decode helpers.
package tisc_pkg;

  localparam int INSTR_W = 16;
  localparam int REG_AW  = 3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_ADDI);
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/tisc_control_unit_if.sv
// Instruction fetch handshake plus register file read/write ports of the TISC core.
interface tisc_control_unit_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) ();
  import tisc_pkg::*;

  logic                 imem_req;
  logic [PC_W-1:0]      imem_addr;
  logic [INSTR_W-1:0]   imem_data;
  logic                 imem_valid;
  logic [REG_AW-1:0]    reg_raddr1;
  logic [REG_AW-1:0]    reg_raddr2;
  logic [DATA_W-1:0]    reg_rdata1;
  logic [DATA_W-1:0]    reg_rdata2;
  logic                 reg_we;
  logic [REG_AW-1:0]    reg_waddr;
  logic [DATA_W-1:0]    reg_wdata;

  modport master (
    output imem_req, imem_addr, reg_raddr1, reg_raddr2, reg_we, reg_waddr, reg_wdata,
    input  imem_data, imem_valid, reg_rdata1, reg_rdata2
  );

  modport slave (
    input  imem_req, imem_addr, reg_raddr1, reg_raddr2, reg_we, reg_waddr, reg_wdata,
    output imem_data, imem_valid, reg_rdata1, reg_rdata2
  );
endinterface

// File: rtl/tisc_alu.sv
// Combinational ALU; results wrap modulo 2^DATA_W, non-writing ops yield 0.
module tisc_alu
  import tisc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        imm8,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] imm_ext;

  assign imm_ext = DATA_W'(imm8);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = imm_ext;
      OP_ADDI: result = a + imm_ext;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/tisc_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller owning PC, IR and halt state.
module tisc_control_unit
  import tisc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  tisc_control_unit_if.master bus,
  output logic                halted,
  output logic                illegal,
  output logic                instr_done
);
  state_t              state_reg;
  logic [INSTR_W-1:0]  ir_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [PC_W-1:0]     next_pc_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [REG_AW-1:0]   waddr_reg;
  logic                we_reg;
  logic                halted_reg;
  logic                illegal_reg;
  logic                done_reg;

  logic [3:0]          op;
  logic [REG_AW-1:0]   rd;
  logic [REG_AW-1:0]   rs1;
  logic [REG_AW-1:0]   rs2;
  logic [7:0]          imm8;
  logic [REG_AW-1:0]   raddr1;
  logic [DATA_W-1:0]   alu_result;
  logic                branch_taken;

  assign op   = ir_reg[OP_MSB:OP_LSB];
  assign rd   = ir_reg[RD_MSB:RD_LSB];
  assign rs1  = ir_reg[RS1_MSB:RS1_LSB];
  assign rs2  = ir_reg[RS2_MSB:RS2_LSB];
  assign imm8 = ir_reg[IMM_MSB:IMM_LSB];

  // ADDI and BEQZ read their destination register through port 1
  always_comb begin
    raddr1 = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: raddr1 = rs1;
      OP_ADDI, OP_BEQZ:                       raddr1 = rd;
      default:                                raddr1 = '0;
    endcase
  end

  tisc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (bus.reg_rdata1),
    .b      (bus.reg_rdata2),
    .imm8   (imm8),
    .result (alu_result)
  );

  assign branch_taken = (op == OP_JMP) || ((op == OP_BEQZ) && (bus.reg_rdata1 == '0));

  assign bus.imem_req   = (state_reg == ST_FETCH);
  assign bus.imem_addr  = pc_reg;
  assign bus.reg_raddr1 = raddr1;
  assign bus.reg_raddr2 = rs2;
  assign bus.reg_we     = we_reg;
  assign bus.reg_waddr  = waddr_reg;
  assign bus.reg_wdata  = result_reg;
  assign halted         = halted_reg;
  assign illegal        = illegal_reg;
  assign instr_done     = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= PC_W'(RESET_PC);
      next_pc_reg <= PC_W'(RESET_PC);
      ir_reg      <= '0;
      result_reg  <= '0;
      waddr_reg   <= '0;
      we_reg      <= 1'b0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      done_reg    <= 1'b0;
      we_reg      <= 1'b0;
      case (state_reg)
        ST_FETCH: begin
          if (bus.imem_valid) begin
            ir_reg      <= bus.imem_data;
            illegal_reg <= op_illegal(bus.imem_data[OP_MSB:OP_LSB]);
            state_reg   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (op == OP_HALT) begin
            halted_reg <= 1'b1;
            done_reg   <= 1'b1;
            state_reg  <= ST_HALT;
          end else begin
            state_reg <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          // write strobe and retire pulse are staged so they land in WRITEBACK
          next_pc_reg <= branch_taken ? PC_W'(imm8) : pc_reg + PC_W'(1);
          result_reg  <= alu_result;
          waddr_reg   <= rd;
          we_reg      <= op_writes(op);
          done_reg    <= 1'b1;
          state_reg   <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          pc_reg    <= next_pc_reg;
          state_reg <= ST_FETCH;
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: state_reg <= ST_FETCH;
      endcase
    end
  end
endmodule
